// File: rtl/wfq_pkg.sv
// ============================================================================
// Module  : wfq_pkg
// Brief   : Shared types and default sizes for the WFQ dequeue controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package wfq_pkg;

    localparam int DEF_PKT_CNT_BITWIDTH = 13;
    localparam int DEF_WDOG_BITWIDTH    = 10;
    localparam int DEF_INIT_FLOOD_COUNT = 8;
    localparam int DEF_TC_ADDR_LATENCY  = 3;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ADDR  = 3'd2,
        S_AWAIT = 3'd3,
        S_READ  = 3'd4,
        S_RWAIT = 3'd5,
        S_DEP   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wfq_dequeue_ctrl_if.sv
// ============================================================================
// Module  : wfq_dequeue_ctrl_if
// Brief   : Request/status bundle between the dequeue controller and its
//           neighbours. wdog_err exists only with WFQ_DEQ_WATCHDOG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface wfq_dequeue_ctrl_if
    import wfq_pkg::*;
#(
    parameter int PKT_CNT_BITWIDTH = DEF_PKT_CNT_BITWIDTH
);
    logic                        in_rd_packet_req;
    logic                        in_packet_arrival;
    logic                        wfq_ftag_odone;
    logic                        sb_empty;
    logic                        sb_packet_read_done;
    logic                        tc_ena2;
    logic                        tc_pak_addr_req;
    logic                        sb_rd_packet_req;
    logic                        wfq_packet_depart;
    logic                        init_done;
    logic                        busy;
    logic [PKT_CNT_BITWIDTH-1:0] backlog;
`ifdef WFQ_DEQ_WATCHDOG_EN
    logic                        wdog_err;
`endif

    modport slave (
        input  in_rd_packet_req, in_packet_arrival, wfq_ftag_odone,
               sb_empty, sb_packet_read_done,
        output tc_ena2, tc_pak_addr_req, sb_rd_packet_req,
               wfq_packet_depart, init_done, busy, backlog
`ifdef WFQ_DEQ_WATCHDOG_EN
        , output wdog_err
`endif
    );

    modport master (
        output in_rd_packet_req, in_packet_arrival, wfq_ftag_odone,
               sb_empty, sb_packet_read_done,
        input  tc_ena2, tc_pak_addr_req, sb_rd_packet_req,
               wfq_packet_depart, init_done, busy, backlog
`ifdef WFQ_DEQ_WATCHDOG_EN
        , input wdog_err
`endif
    );

endinterface

`default_nettype wire

// File: rtl/wfq_sat_updown_cnt.sv
// ============================================================================
// Module  : wfq_sat_updown_cnt
// Brief   : Up/down counter that saturates at both ends; inc and dec in the
//           same cycle cancel out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wfq_sat_updown_cnt #(
    parameter int WIDTH = 13
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc_i,
    input  wire logic             dec_i,
    output logic      [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/wfq_dequeue_ctrl.sv
// ============================================================================
// Module  : wfq_dequeue_ctrl
// Brief   : Sequences tag-tree flood, min-tag fetch, buffer read and depart
//           notification for the WFQ datapath, one packet in flight.
//           Optional: WFQ_DEQ_WATCHDOG_EN adds a read-completion watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wfq_dequeue_ctrl
    import wfq_pkg::*;
#(
    parameter int INIT_FLOOD_COUNT = DEF_INIT_FLOOD_COUNT,
    parameter int TC_ADDR_LATENCY  = DEF_TC_ADDR_LATENCY,
    parameter int PKT_CNT_BITWIDTH = DEF_PKT_CNT_BITWIDTH
`ifdef WFQ_DEQ_WATCHDOG_EN
    , parameter int WDOG_BITWIDTH  = DEF_WDOG_BITWIDTH
`endif
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wfq_dequeue_ctrl_if.slave bus
);

    localparam int FLOOD_W = $clog2(INIT_FLOOD_COUNT + 1);
    localparam int WAIT_W  = (TC_ADDR_LATENCY > 1) ? $clog2(TC_ADDR_LATENCY) : 1;

    state_t                      state_q, state_d;
    logic [FLOOD_W-1:0]          flood_cnt_q, flood_cnt_d;
    logic                        init_done_q;
    logic [WAIT_W-1:0]           wait_q, wait_d;
    logic                        seen_low_q, seen_low_d;
`ifdef WFQ_DEQ_WATCHDOG_EN
    logic [WDOG_BITWIDTH-1:0]    wdog_q, wdog_d;
    logic                        wdog_err_q, wdog_err_d;
`endif

    logic                        w_flood_full;
    logic                        w_addr_req;
    logic                        w_rd_req;
    logic                        w_depart;
    logic [PKT_CNT_BITWIDTH-1:0] w_pending;
    logic [PKT_CNT_BITWIDTH-1:0] w_backlog;

    assign w_flood_full = (flood_cnt_q == FLOOD_W'(INIT_FLOOD_COUNT));

    always_comb begin
        flood_cnt_d = flood_cnt_q;
        if (bus.wfq_ftag_odone && !w_flood_full) begin
            flood_cnt_d = flood_cnt_q + FLOOD_W'(1);
        end
    end

    wfq_sat_updown_cnt #(.WIDTH(PKT_CNT_BITWIDTH)) u_pending_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (bus.in_rd_packet_req),
        .dec_i   (w_rd_req),
        .count_o (w_pending)
    );

    wfq_sat_updown_cnt #(.WIDTH(PKT_CNT_BITWIDTH)) u_backlog_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (bus.in_packet_arrival),
        .dec_i   (w_depart),
        .count_o (w_backlog)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        seen_low_d = seen_low_q;
        w_addr_req = 1'b0;
        w_rd_req   = 1'b0;
        w_depart   = 1'b0;
`ifdef WFQ_DEQ_WATCHDOG_EN
        wdog_d     = wdog_q;
        wdog_err_d = wdog_err_q;
`endif
        case (state_q)
            S_INIT: begin
                if (w_flood_full) state_d = S_IDLE;
            end
            S_IDLE: begin
                if ((w_pending != '0) && (w_backlog != '0) &&
                    !bus.sb_empty && bus.sb_packet_read_done) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                w_addr_req = 1'b1;
                wait_d     = WAIT_W'(TC_ADDR_LATENCY - 1);
                state_d    = S_AWAIT;
            end
            S_AWAIT: begin
                if (wait_q == '0) state_d = S_READ;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_READ: begin
                w_rd_req   = 1'b1;
                seen_low_d = 1'b0;
`ifdef WFQ_DEQ_WATCHDOG_EN
                wdog_d     = '0;
`endif
                state_d    = S_RWAIT;
            end
            S_RWAIT: begin
                // A done level still high from the previous packet must fall first.
                if (!seen_low_q) begin
                    if (!bus.sb_packet_read_done) seen_low_d = 1'b1;
                end else if (bus.sb_packet_read_done) begin
                    state_d = S_DEP;
                end
`ifdef WFQ_DEQ_WATCHDOG_EN
                wdog_d = wdog_q + WDOG_BITWIDTH'(1);
                if (wdog_q == '1) begin
                    state_d    = S_IDLE;
                    wdog_err_d = 1'b1;
                end
`endif
            end
            S_DEP: begin
                w_depart = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            flood_cnt_q <= '0;
            init_done_q <= 1'b0;
            wait_q      <= '0;
            seen_low_q  <= 1'b0;
`ifdef WFQ_DEQ_WATCHDOG_EN
            wdog_q      <= '0;
            wdog_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            flood_cnt_q <= flood_cnt_d;
            init_done_q <= w_flood_full;
            wait_q      <= wait_d;
            seen_low_q  <= seen_low_d;
`ifdef WFQ_DEQ_WATCHDOG_EN
            wdog_q      <= wdog_d;
            wdog_err_q  <= wdog_err_d;
`endif
        end
    end

    assign bus.tc_ena2           = bus.wfq_ftag_odone & init_done_q;
    assign bus.tc_pak_addr_req   = w_addr_req;
    assign bus.sb_rd_packet_req  = w_rd_req;
    assign bus.wfq_packet_depart = w_depart;
    assign bus.init_done         = init_done_q;
    assign bus.busy              = (state_q != S_IDLE) && (state_q != S_INIT);
    assign bus.backlog           = w_backlog;
`ifdef WFQ_DEQ_WATCHDOG_EN
    assign bus.wdog_err          = wdog_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wfq_dequeue_ctrl.sv
// ============================================================================
// Module  : tb_wfq_dequeue_ctrl
// Brief   : Directed self-checking bench for wfq_dequeue_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wfq_dequeue_ctrl;
    import wfq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_addr = 0, n_rd = 0, n_dep = 0;
    int   t_addr = 0, t_rd = 0;

    wfq_dequeue_ctrl_if #(.PKT_CNT_BITWIDTH(13)) bus ();

    wfq_dequeue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tc_pak_addr_req)   begin n_addr <= n_addr + 1; t_addr <= cyc; end
        if (bus.sb_rd_packet_req)  begin n_rd   <= n_rd + 1;   t_rd   <= cyc; end
        if (bus.wfq_packet_depart) n_dep <= n_dep + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flood();
        for (int i = 0; i < 8; i++) begin
            bus.wfq_ftag_odone = 1'b1;
            #1;
            chk("ena2_during_flood", {31'd0, bus.tc_ena2}, 0);
            @(posedge clk);
            #1;
            bus.wfq_ftag_odone = 1'b0;
            step();
        end
    endtask

    // Plays the shared buffer: keeps done high briefly (stale), drops it, re-raises it.
    task automatic serve_read(input bit arrive_at_dep);
        int rd0;
        int dep0;
        rd0  = n_rd;
        dep0 = n_dep;
        for (int i = 0; i < 40 && n_rd == rd0; i++) step();
        chk("rd_issued", n_rd - rd0, 1);
        step();
        step();
        chk("stale_done_ignored", n_dep - dep0, 0);
        bus.sb_packet_read_done = 1'b0;
        step();
        step();
        bus.sb_packet_read_done = 1'b1;
        step();
        chk("depart_after_rerise", {31'd0, bus.wfq_packet_depart}, 1);
        if (arrive_at_dep) bus.in_packet_arrival = 1'b1;
        step();
        bus.in_packet_arrival = 1'b0;
        chk("one_depart", n_dep - dep0, 1);
    endtask

    task automatic pulse_req();
        bus.in_rd_packet_req = 1'b1;
        step();
        bus.in_rd_packet_req = 1'b0;
    endtask

    task automatic pulse_arrival();
        bus.in_packet_arrival = 1'b1;
        step();
        bus.in_packet_arrival = 1'b0;
    endtask

    initial begin
        int c0;
        int a0;
        int r0;
        bus.in_rd_packet_req    = 1'b0;
        bus.in_packet_arrival   = 1'b0;
        bus.wfq_ftag_odone      = 1'b0;
        bus.sb_empty            = 1'b1;
        bus.sb_packet_read_done = 1'b1;

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_init_done", {31'd0, bus.init_done}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_backlog", 32'(bus.backlog), 0);
        chk("rst_addr_req", {31'd0, bus.tc_pak_addr_req}, 0);
        chk("rst_rd_req", {31'd0, bus.sb_rd_packet_req}, 0);
        chk("rst_depart", {31'd0, bus.wfq_packet_depart}, 0);
`ifdef WFQ_DEQ_WATCHDOG_EN
        chk("rst_wdog_err", {31'd0, bus.wdog_err}, 0);
`endif

        // Flood: ena2 held off for 8 pulses, passes the 9th
        flood();
        step();
        chk("init_done_after_flood", {31'd0, bus.init_done}, 1);
        bus.wfq_ftag_odone = 1'b1;
        #1;
        chk("ena2_ninth", {31'd0, bus.tc_ena2}, 1);
        step();
        bus.wfq_ftag_odone = 1'b0;

        // Single packet latency
        pulse_arrival();
        chk("backlog_one", 32'(bus.backlog), 1);
        bus.sb_empty = 1'b0;
        c0 = cyc;
        pulse_req();
        serve_read(1'b0);
        chk("lat_req_to_addr", t_addr - c0, 2);
        chk("lat_addr_to_rd", t_rd - t_addr, 4);
        chk("backlog_zero", 32'(bus.backlog), 0);
        chk("idle_after_dep", {31'd0, bus.busy}, 0);

        // Requests with nothing stored stay pending
        a0 = n_addr;
        repeat (3) begin pulse_req(); step(); end
        repeat (10) step();
        chk("no_addr_without_backlog", n_addr - a0, 0);
        pulse_arrival();
        pulse_arrival();
        serve_read(1'b0);
        serve_read(1'b0);
        chk("two_sequences", n_addr - a0, 2);
        repeat (10) step();
        chk("no_third_sequence", n_addr - a0, 2);
        pulse_arrival();
        serve_read(1'b0);
        chk("one_pending_left", n_addr - a0, 3);
        pulse_arrival();
        repeat (15) step();
        chk("pending_exhausted", n_addr - a0, 3);

        // Arrival coincident with depart
        repeat (4) pulse_arrival();
        chk("backlog_five", 32'(bus.backlog), 5);
        pulse_req();
        serve_read(1'b1);
        chk("backlog_arr_dep_same", 32'(bus.backlog), 5);

        // Reset in the middle of the address wait
        pulse_req();
        step();
        step();
        chk("busy_in_await", {31'd0, bus.busy}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_init_done", {31'd0, bus.init_done}, 0);
        chk("midrst_busy", {31'd0, bus.busy}, 0);
        chk("midrst_backlog", 32'(bus.backlog), 0);
        chk("midrst_rd_req", {31'd0, bus.sb_rd_packet_req}, 0);
        r0 = n_rd;
        pulse_req();
        pulse_arrival();
        repeat (15) step();
        chk("no_rd_before_reflood", n_rd - r0, 0);
        flood();
        step();
        chk("reflood_init_done", {31'd0, bus.init_done}, 1);
        serve_read(1'b0);
        chk("reflood_backlog", 32'(bus.backlog), 0);

`ifdef WFQ_DEQ_WATCHDOG_EN
        begin
            int d0;
            d0 = n_dep;
            r0 = n_rd;
            pulse_arrival();
            pulse_req();
            for (int i = 0; i < 40 && n_rd == r0; i++) step();
            bus.sb_packet_read_done = 1'b0;
            repeat (1100) step();
            chk("wdog_err_set", {31'd0, bus.wdog_err}, 1);
            chk("wdog_idle", {31'd0, bus.busy}, 0);
            chk("wdog_no_depart", n_dep - d0, 0);
            chk("wdog_backlog_kept", 32'(bus.backlog), 1);
            bus.sb_packet_read_done = 1'b1;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wfq_dequeue_ctrl.md
Name: wfq_dequeue_ctrl

Overview:
- Sequences packet departures for the WFQ datapath: tag-circuit flood/init, minimum-tag address fetch, shared-buffer packet read, and the WFQ depart notification.
- Sits between the egress read-request source and the tag circuit / shared buffer / WFQ computation blocks.
- Replaces free-running delay lines with an explicit FSM plus a pending-request counter and a backlog counter.

Parameters:
- INIT_FLOOD_COUNT, 8, number of wfq_ftag_odone pulses that flood the tag tree before tc_ena2 is released.
- TC_ADDR_LATENCY, 3, cycles from the tc_pak_addr_req pulse to a valid tc_pak_addr_min_out.
- PKT_CNT_BITWIDTH, 13, width of the backlog and pending counters.
- WDOG_BITWIDTH, 10, watchdog counter width (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_rd_packet_req  in  1  egress request pulse: one pulse = one packet wanted.
- in_packet_arrival  in  1  packet arrival pulse, already gated by !sb_full.
- wfq_ftag_odone  in  1  finish-tag valid pulse from WFQ computation.
- sb_empty  in  1  shared buffer empty.
- sb_packet_read_done  in  1  level: shared buffer idle, last packet fully read.
- tc_ena2  out  1  wfq_ftag_odone gated until init completes.
- tc_pak_addr_req  out  1  one-cycle pulse: pop minimum tag.
- sb_rd_packet_req  out  1  one-cycle pulse: start packet read at sb_ip.
- wfq_packet_depart  out  1  one-cycle pulse to WFQ computation.
- init_done  out  1  high once the flood is complete.
- busy  out  1  FSM not in S_IDLE or S_INIT.
- backlog  out  PKT_CNT_BITWIDTH  packets stored and not yet departed.

Behaviour:
- Reset: all outputs 0; FSM in S_INIT; flood, pending and backlog counters 0.
- tc_ena2 = wfq_ftag_odone & init_done (combinational).
- Flood counter:
  - Increments on each wfq_ftag_odone while below INIT_FLOOD_COUNT.
  - init_done registers high the cycle after the count reaches INIT_FLOOD_COUNT.
  - S_INIT -> S_IDLE at the same edge.
- Pending counter:
  - +1 on in_rd_packet_req, saturates at all-ones.
  - -1 on the cycle sb_rd_packet_req is issued.
  - Simultaneous +1 and -1: unchanged.
  - Requests during S_INIT are accumulated.
- Backlog counter:
  - +1 on in_packet_arrival, -1 on wfq_packet_depart.
  - Simultaneous: unchanged. Saturates at max. Never decrements below 0.
- FSM states:
  - S_INIT: waits for flood completion.
  - S_IDLE: if pending!=0 && backlog!=0 && !sb_empty && sb_packet_read_done, go to S_ADDR.
  - S_ADDR: tc_pak_addr_req=1 for exactly this cycle; go to S_AWAIT and load the wait counter with TC_ADDR_LATENCY-1.
  - S_AWAIT: count down; at 0 go to S_READ.
  - S_READ: sb_rd_packet_req=1 for one cycle; go to S_RWAIT.
  - S_RWAIT: wait for sb_packet_read_done to fall then rise again (two-phase, so a stale "done" is ignored); then go to S_DEP.
  - S_DEP: wfq_packet_depart=1 for one cycle; go to S_IDLE.
- Latency: request pulse to tc_pak_addr_req = 2 cycles when idle and all conditions hold. tc_pak_addr_req to sb_rd_packet_req = TC_ADDR_LATENCY+1 cycles.
- Back-to-back: at most one packet in flight; the next S_ADDR follows at the earliest 1 cycle after S_DEP.
- Boundary cases:
  - Requests with backlog==0 stay pending; no pulses are issued.
  - sb_empty while in S_AWAIT or later does not abort the in-flight read.
  - rst mid-operation returns to S_INIT and requires a new flood.

Optional Feature:
- WFQ_DEQ_WATCHDOG_EN defined:
  - An WDOG_BITWIDTH counter runs in S_RWAIT.
  - On reaching all-ones, the FSM goes to S_IDLE without a depart pulse, and the sticky output port wdog_err (1 bit) is set; it is cleared only by rst.
  - Backlog is not decremented.
- Undefined: no counter, no wdog_err port; S_RWAIT waits indefinitely.

Decomposition:
- Package wfq_pkg: FSM state enum, default widths (PKT_CNT_BITWIDTH, WDOG_BITWIDTH), INIT_FLOOD_COUNT constant.
- Sub-module wfq_sat_updown_cnt: saturating up/down counter with simultaneous inc/dec; used for both pending and backlog.

Test Plan:
- Reset, 8 wfq_ftag_odone pulses -> tc_ena2 stays 0 for all 8; init_done=1 after the 8th; the 9th odone produces tc_ena2=1.
- init_done, backlog=1, one in_rd_packet_req at cycle 0 -> tc_pak_addr_req at cycle 2, sb_rd_packet_req at cycle 6; depart 1 cycle after read_done re-rises; backlog=0.
- 3 requests, backlog=0 -> no pulses; then 2 arrivals -> exactly 2 read sequences; pending=1 left.
- Arrival and depart in the same cycle with backlog=5 -> backlog stays 5.
- rst asserted in S_AWAIT -> all outputs 0 next cycle; no sb_rd_packet_req until a re-flood and a new request.
- With WFQ_DEQ_WATCHDOG_EN and read_done held low for 1023 cycles in S_RWAIT -> wdog_err=1, FSM in S_IDLE, no wfq_packet_depart.
